// File: rtl/hazard_fwd_unit.sv
// Operand forwarding and load-use hazard control for the DE/EXE/ACC pipeline.
// Resolves DE sources against in-flight writers and stalls DE until load data arrives.
module hazard_fwd_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    de_valid,
  input  logic [NUM_SRC*RA_W-1:0] de_rs,
  input  logic [NUM_SRC-1:0]      de_rs_used,
  input  logic                    exe_valid,
  input  logic                    exe_wb_en,
  input  logic [RA_W-1:0]         exe_rd,
  input  logic [1:0]              exe_wb_sel,
  input  logic [XLEN-1:0]         exe_alu_out,
  input  logic [XLEN-1:0]         exe_pc_4,
  input  logic                    acc_valid,
  input  logic                    acc_wb_en,
  input  logic [RA_W-1:0]         acc_rd,
  input  logic [1:0]              acc_wb_sel,
  input  logic [XLEN-1:0]         acc_alu_out,
  input  logic [XLEN-1:0]         acc_dmem_out,
  input  logic [XLEN-1:0]         acc_pc_4,
  input  logic                    acc_mem_rdy,
  output logic                    stall,
  output logic [NUM_SRC-1:0]      fwd_en,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [RA_W-1:0]   pend_rd;
  logic              hold_valid;
  logic [XLEN-1:0]   hold_data;

  logic [NUM_SRC-1:0] exe_hit;
  logic [NUM_SRC-1:0] acc_hit;
  logic [NUM_SRC-1:0] hold_hit;
  logic [XLEN-1:0]    exe_val;
  logic [XLEN-1:0]    acc_val;
  logic               exe_is_load;
  logic               acc_ld_pending;
  logic               exe_ld_haz;
  logic               acc_ld_haz;
  logic               load_haz;
  logic [RA_W-1:0]    pend_src;
  logic               release_ld;
  logic               stall_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic producer_hit(input logic s_valid, input logic s_wb_en,
                                        input logic [1:0] s_sel, input logic [RA_W-1:0] s_rd,
                                        input logic [RA_W-1:0] rs, input logic used);
    return de_valid & used & (rs != '0) & s_valid & s_wb_en &
           (s_sel != SEL_NONE) & (s_rd == rs);
  endfunction

  // Stage result candidates
  always_comb begin
    exe_val = (exe_wb_sel == SEL_PC4) ? exe_pc_4 : exe_alu_out;
    case (acc_wb_sel)
      SEL_LOAD: acc_val = acc_dmem_out;
      SEL_PC4:  acc_val = acc_pc_4;
      default:  acc_val = acc_alu_out;
    endcase
    exe_is_load    = (exe_wb_sel == SEL_LOAD);
    acc_ld_pending = (acc_wb_sel == SEL_LOAD) & ~acc_mem_rdy;
  end

  always_comb begin
    logic [RA_W-1:0] rs;
    rs       = '0;
    exe_hit  = '0;
    acc_hit  = '0;
    hold_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs          = de_rs[i*RA_W +: RA_W];
      exe_hit[i]  = producer_hit(exe_valid, exe_wb_en, exe_wb_sel, exe_rd, rs, de_rs_used[i]);
      acc_hit[i]  = producer_hit(acc_valid, acc_wb_en, acc_wb_sel, acc_rd, rs, de_rs_used[i]);
      hold_hit[i] = hold_valid & (pend_rd == rs) & (rs != '0);
    end
  end

  // Hazard detection and stall generation
  always_comb begin
    exe_ld_haz = (|exe_hit) & exe_is_load;
    // An ACC load only stalls when no younger EXE writer shadows it for that slot
    acc_ld_haz = (|(acc_hit & ~exe_hit)) & acc_ld_pending;
    load_haz   = exe_ld_haz | acc_ld_haz;
    pend_src   = exe_ld_haz ? exe_rd : acc_rd;
    release_ld = (state == WAIT) & acc_valid & (acc_rd == pend_rd) &
                 (acc_wb_sel == SEL_LOAD) & acc_mem_rdy;
    stall_c    = ~rst & ~flush & ((state == IDLE) ? load_haz : ~release_ld);
  end

  assign stall = stall_c;

  // Per-slot forwarding mux: EXE, then ACC, then hold buffer
  always_comb begin
    fwd_en   = '0;
    fwd_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exe_hit[i]) begin
        if (!exe_is_load) begin
          fwd_en[i]                 = 1'b1;
          fwd_data[i*XLEN +: XLEN]  = exe_val;
        end
      end else if (acc_hit[i]) begin
        if (!acc_ld_pending) begin
          fwd_en[i]                 = 1'b1;
          fwd_data[i*XLEN +: XLEN]  = acc_val;
        end
      end else if (hold_hit[i]) begin
        fwd_en[i]                   = 1'b1;
        fwd_data[i*XLEN +: XLEN]    = hold_data;
      end
    end
    if (rst) begin
      fwd_en   = '0;
      fwd_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_rd    <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (stall_c) stall_cnt <= sat_inc(stall_cnt);

      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (load_haz) begin
            state   <= WAIT;
            pend_rd <= pend_src;
          end
          WAIT: if (release_ld) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A fresh capture wins over the advance-clear
      if (flush) begin
        hold_valid <= 1'b0;
      end else if (release_ld) begin
        hold_valid <= 1'b1;
        hold_data  <= acc_dmem_out;
      end else if (de_valid & ~stall_c) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: per-cycle expectations are queued as stimulus
// is driven and compared against outputs sampled on the falling edge.
module tb_hazard_fwd_unit;

  localparam int XLEN = 32, NUM_SRC = 2, RA_W = 5, CNT_W = 4;

  logic                    clk = 1'b0;
  logic                    rst, flush, de_valid;
  logic [NUM_SRC*RA_W-1:0] de_rs;
  logic [NUM_SRC-1:0]      de_rs_used;
  logic                    exe_valid, exe_wb_en;
  logic [RA_W-1:0]         exe_rd;
  logic [1:0]              exe_wb_sel;
  logic [XLEN-1:0]         exe_alu_out, exe_pc_4;
  logic                    acc_valid, acc_wb_en;
  logic [RA_W-1:0]         acc_rd;
  logic [1:0]              acc_wb_sel;
  logic [XLEN-1:0]         acc_alu_out, acc_dmem_out, acc_pc_4;
  logic                    acc_mem_rdy;
  logic                    stall;
  logic [NUM_SRC-1:0]      fwd_en;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic [CNT_W-1:0]        stall_cnt;

  hazard_fwd_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .de_valid(de_valid), .de_rs(de_rs),
    .de_rs_used(de_rs_used), .exe_valid(exe_valid), .exe_wb_en(exe_wb_en),
    .exe_rd(exe_rd), .exe_wb_sel(exe_wb_sel), .exe_alu_out(exe_alu_out),
    .exe_pc_4(exe_pc_4), .acc_valid(acc_valid), .acc_wb_en(acc_wb_en),
    .acc_rd(acc_rd), .acc_wb_sel(acc_wb_sel), .acc_alu_out(acc_alu_out),
    .acc_dmem_out(acc_dmem_out), .acc_pc_4(acc_pc_4), .acc_mem_rdy(acc_mem_rdy),
    .stall(stall), .fwd_en(fwd_en), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    logic [1:0]  fen;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic st, input logic [1:0] fen,
                          input logic [31:0] d0, input logic [31:0] d1, input int cnt);
    exp_t e;
    e.tag = tag; e.stall = st; e.fen = fen; e.d0 = d0; e.d1 = d1; e.cnt = cnt[3:0];
    sb.push_back(e);
  endtask

  task automatic compare_front;
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".stall"},     {31'd0, stall},     {31'd0, e.stall});
      chk({e.tag, ".fwd_en"},    {30'd0, fwd_en},    {30'd0, e.fen});
      chk({e.tag, ".d0"},        fwd_data[31:0],     e.d0);
      chk({e.tag, ".d1"},        fwd_data[63:32],    e.d1);
      chk({e.tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e.cnt});
    end
  endtask

  task automatic step;
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    flush = 0; de_valid = 0; de_rs = '0; de_rs_used = '0;
    exe_valid = 0; exe_wb_en = 0; exe_rd = '0; exe_wb_sel = 2'b11;
    exe_alu_out = '0; exe_pc_4 = '0;
    acc_valid = 0; acc_wb_en = 0; acc_rd = '0; acc_wb_sel = 2'b11;
    acc_alu_out = '0; acc_dmem_out = '0; acc_pc_4 = '0; acc_mem_rdy = 0;
  endtask

  task automatic drv_de(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used);
    de_valid = v; de_rs = {rs1, rs0}; de_rs_used = used;
  endtask

  task automatic drv_exe(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4);
    exe_valid = v; exe_wb_en = v; exe_rd = rd; exe_wb_sel = sel;
    exe_alu_out = alu; exe_pc_4 = pc4;
  endtask

  task automatic drv_acc(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] dmem,
                         input logic [31:0] pc4, input logic rdy);
    acc_valid = v; acc_wb_en = v; acc_rd = rd; acc_wb_sel = sel;
    acc_alu_out = alu; acc_dmem_out = dmem; acc_pc_4 = pc4; acc_mem_rdy = rdy;
  endtask

  initial begin
    set_idle();
    rst = 1;
    // Hazard and forwardable producer present while reset is held
    drv_de(1, 5'd8, 5'd7, 2'b11);
    drv_exe(1, 5'd8, 2'b01, 32'h0, 32'h0);
    drv_acc(1, 5'd7, 2'b00, 32'h77, 32'h0, 32'h0, 1);
    push_exp("reset", 0, 2'b00, 0, 0, 0); step();
    rst = 0; set_idle();

    drv_de(1, 5'd5, 5'd7, 2'b11);
    drv_exe(1, 5'd5, 2'b00, 32'h1234, 32'h0);
    push_exp("exe_alu", 0, 2'b01, 32'h1234, 0, 0); step();

    drv_de(1, 5'd5, 5'd7, 2'b00);
    push_exp("unused_slot", 0, 2'b00, 0, 0, 0); step();

    drv_de(1, 5'd9, 5'd3, 2'b11);
    drv_exe(1, 5'd3, 2'b00, 32'hAAAA, 32'h0);
    drv_acc(1, 5'd3, 2'b00, 32'hBBBB, 32'h0, 32'h0, 1);
    push_exp("exe_over_acc", 0, 2'b10, 0, 32'hAAAA, 0); step();

    drv_de(1, 5'd9, 5'd0, 2'b11);
    drv_exe(1, 5'd0, 2'b00, 32'hAAAA, 32'h0);
    drv_acc(1, 5'd0, 2'b00, 32'hBBBB, 32'h0, 32'h0, 1);
    push_exp("x0_never", 0, 2'b00, 0, 0, 0); step();

    drv_de(1, 5'd9, 5'd3, 2'b11);
    drv_exe(1, 5'd3, 2'b11, 32'hAAAA, 32'h0);
    drv_acc(1, 5'd3, 2'b00, 32'hBBBB, 32'h0, 32'h0, 1);
    push_exp("acc_alu", 0, 2'b10, 0, 32'hBBBB, 0); step();

    drv_de(1, 5'd2, 5'd0, 2'b01);
    drv_exe(1, 5'd2, 2'b10, 32'h777, 32'h200);
    drv_acc(0, 5'd0, 2'b11, 0, 0, 0, 0);
    push_exp("exe_pc4", 0, 2'b01, 32'h200, 0, 0); step();

    drv_de(1, 5'd1, 5'd1, 2'b11);
    drv_exe(0, 5'd0, 2'b11, 0, 0);
    drv_acc(1, 5'd1, 2'b10, 32'h999, 32'h0, 32'h104, 0);
    push_exp("jalr_both", 0, 2'b11, 32'h104, 32'h104, 0); step();

    // Load-use: EXE load, ACC not ready twice, then ready
    drv_de(1, 5'd8, 5'd0, 2'b01);
    drv_exe(1, 5'd8, 2'b01, 32'h5555, 32'h0);
    drv_acc(0, 5'd0, 2'b11, 0, 0, 0, 0);
    push_exp("ld_exe", 1, 2'b00, 0, 0, 0); step();
    drv_exe(0, 5'd0, 2'b11, 0, 0);
    drv_acc(1, 5'd8, 2'b01, 32'h0, 32'h0, 32'h0, 0);
    push_exp("ld_wait1", 1, 2'b00, 0, 0, 1); step();
    push_exp("ld_wait2", 1, 2'b00, 0, 0, 2); step();
    drv_acc(1, 5'd8, 2'b01, 32'h0, 32'hDEAD, 32'h0, 1);
    push_exp("ld_ready", 0, 2'b01, 32'hDEAD, 0, 3); step();
    drv_acc(0, 5'd0, 2'b11, 0, 0, 0, 0);
    push_exp("hold_fwd", 0, 2'b01, 32'hDEAD, 0, 3); step();
    push_exp("hold_clr", 0, 2'b00, 0, 0, 3); step();

    // Flush during WAIT, then an identical hazard re-stalls
    drv_exe(1, 5'd8, 2'b01, 32'h0, 32'h0);
    push_exp("fl_haz", 1, 2'b00, 0, 0, 3); step();
    drv_exe(0, 5'd0, 2'b11, 0, 0);
    drv_acc(1, 5'd8, 2'b01, 32'h0, 32'h0, 32'h0, 0);
    flush = 1;
    push_exp("fl_flush", 0, 2'b00, 0, 0, 4); step();
    set_idle();
    push_exp("fl_idle", 0, 2'b00, 0, 0, 4); step();
    drv_de(1, 5'd8, 5'd0, 2'b01);
    drv_exe(1, 5'd8, 2'b01, 32'h0, 32'h0);
    push_exp("fl_restall", 1, 2'b00, 0, 0, 4); step();

    // Long WAIT drives the counter into saturation
    drv_exe(0, 5'd0, 2'b11, 0, 0);
    for (int k = 0; k < 21; k++) begin
      push_exp("sat", 1, 2'b00, 0, 0, (5 + k > 15) ? 15 : 5 + k);
      step();
    end

    // Asynchronous reset in the middle of WAIT
    #3;
    rst = 1;
    #1;
    push_exp("async_rst", 0, 2'b00, 0, 0, 0);
    compare_front();
    @(posedge clk); #1;
    rst = 0;
    push_exp("post_rst", 0, 2'b00, 0, 0, 0); step();
    drv_exe(1, 5'd8, 2'b01, 32'h0, 32'h0);
    push_exp("post_rst_haz", 1, 2'b00, 0, 0, 0); step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised forwarding and load-use hazard controller for the rv32 pipeline (DE/EXE/ACC stages). It resolves up to NUM_SRC source operands in DE against the in-flight destinations in EXE and ACC, and forwards the correct write-back value. On a load-use hazard it stalls DE through a small FSM until ACC reports load data ready, then holds that data for DE.
It also keeps a saturating stall-cycle performance counter.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 2, number of DE source operands checked (1..4)
RA_W, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset; rst is asynchronous, active-high; clock is clk
flush  in  1  pipeline redirect; kills the pending hazard
de_valid  in  1  DE holds a valid instruction
de_rs  in  NUM_SRC*RA_W  source register addresses, slot i at [i*RA_W +: RA_W]
de_rs_used  in  NUM_SRC  slot i actually reads de_rs[i]
exe_valid, exe_wb_en  in  1 each  EXE instruction valid / writes rd
exe_rd  in  RA_W  EXE destination
exe_wb_sel  in  2  00 ALU, 01 memory load, 10 PC+4, 11 none
exe_alu_out, exe_pc_4  in  XLEN each  EXE result candidates
acc_valid, acc_wb_en  in  1 each  ACC valid / writes rd
acc_rd  in  RA_W  ACC destination
acc_wb_sel  in  2  same encoding as exe_wb_sel
acc_alu_out, acc_dmem_out, acc_pc_4  in  XLEN each  ACC result candidates
acc_mem_rdy  in  1  acc_dmem_out valid this cycle
stall  out  1  freeze PC/DE, insert bubble into EXE
fwd_en  out  NUM_SRC  slot i takes fwd_data instead of regfile
fwd_data  out  NUM_SRC*XLEN  forwarded operand per slot
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Producer match for slot i, stage S: S_valid & S_wb_en & S_wb_sel!=11 & S_rd==de_rs[i] & de_rs[i]!=0 & de_rs_used[i] & de_valid. Register x0 is never forwarded and never stalls.
- Forward priority per slot: EXE > ACC > hold buffer > none (fwd_en=0, fwd_data=0).
- EXE value: ALU->exe_alu_out, PC+4->exe_pc_4. EXE load match = load-use hazard; EXE is not forwarded.
- ACC value: ALU->acc_alu_out, PC+4->acc_pc_4, load->acc_dmem_out only if acc_mem_rdy. If not ready, treat as a hazard (stall).
- Forwarding mux and stall are combinational, with zero latency in the same cycle.
- FSM states:
  - IDLE: a load-use hazard in EXE, or an unready ACC load match, asserts stall. Next state WAIT; latch pend_rd = load rd.
  - WAIT: stall=1 while the FSM is in WAIT. When acc_valid & acc_rd==pend_rd & acc_wb_sel==01 & acc_mem_rdy: capture acc_dmem_out into hold_data, set hold_valid, stall=0 that same cycle, next state IDLE.
  - flush in any state: next state IDLE, clear hold_valid, stall=0 that cycle.
- Hold buffer:
  - Matches slot i when hold_valid & pend_rd==de_rs[i] & de_rs[i]!=0.
  - Cleared the cycle after DE advances (de_valid & ~stall), or on flush.
  - A new capture overrides the clear.
- Multiple slots on the same rd all forward the same value. Any slot hazard stalls the whole DE.
- stall_cnt increments by 1 each cycle stall=1 and saturates at all-ones (no wrap). It is not cleared by flush.
- Reset values: FSM IDLE, pend_rd=0, hold_valid=0, hold_data=0, stall_cnt=0. While rst is high, stall=0 and fwd_en=0 regardless of inputs.
- Reset mid-WAIT aborts the stall immediately, asynchronously.

Test Plan:
- EXE ALU rd=5 (exe_alu_out=0x1234), DE rs0=5, rs1=7 -> fwd_en=01, slot0 data 0x1234, stall=0.
- EXE and ACC both write rd=3 (0xAAAA vs 0xBBBB), DE rs1=3 -> slot1=0xAAAA (EXE wins); same scenario with rd=0 -> fwd_en=00.
- EXE load rd=8, DE rs0=8; then ACC with acc_mem_rdy low for 2 cycles, then high with dmem=0xDEAD -> stall high 3 cycles, low on the ready cycle, slot0=0xDEAD, stall_cnt=3, hold cleared after DE advances.
- JALR in ACC rd=1, acc_pc_4=0x104, DE rs0=rs1=1 -> both slots 0x104, fwd_en=11.
- Flush asserted during WAIT -> stall=0 that cycle, FSM IDLE, hold_valid=0; next identical hazard re-stalls.
- Force stall for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt sticks at 0xF; assert rst mid-WAIT -> stall drops asynchronously, stall_cnt=0.
